vec_alu_seq: RTL

//  Upstream sequencer for the 32-bit scalar ALU in the vector datapath. Accepts one

---
 rtl/vec_pkg.sv | 24 ++
 rtl/vec_elem_sel.sv | 20 ++
 rtl/vec_alu_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath: ALU op codes, element width,
// default vector length and the sequencer state encoding.
package vec_pkg;

  localparam int EW       = 32;
  localparam int VLEN_DEF = 4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_XOR = 4'd2,
    ALU_LSL = 4'd3,
    ALU_LSR = 4'd4,
    ALU_ROR = 4'd5,
    ALU_ROL = 4'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/vec_elem_sel.sv
// Picks one EW-bit element out of a packed vector by index; an index at or
// beyond VLEN yields zero.
module vec_elem_sel #(
  parameter int VLEN = 4,
  parameter int EW   = 32,
  parameter int IW   = $clog2(VLEN + 1)
) (
  input  logic [VLEN*EW-1:0] vec_i,
  input  logic [IW-1:0]      idx_i,
  output logic [EW-1:0]      elem_o
);

  always_comb begin
    elem_o = '0;
    for (int i = 0; i < VLEN; i++) begin
      if (idx_i == IW'(i)) elem_o = vec_i[i*EW +: EW];
    end
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Vector-to-scalar ALU sequencer: streams one element per clock through an
// external ALU and packs the results. Optional feature macro: VSEQ_BCAST_EN.
module vec_alu_seq
  import vec_pkg::*;
#(
  parameter  int VLEN = VLEN_DEF,
  localparam int VW   = $clog2(VLEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ctl,
  input  logic [VLEN*EW-1:0] in_va,
  input  logic [VLEN*EW-1:0] in_vb,
  input  logic [VW-1:0]     in_vl,
`ifdef VSEQ_BCAST_EN
  input  logic              in_bcast,
`endif
  output logic [3:0]        alu_ctl,
  output logic [EW-1:0]     alu_a,
  output logic [EW-1:0]     alu_b,
  input  logic [EW-1:0]     alu_out,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN*EW-1:0] out_vd,
  output logic [VLEN-1:0]   out_zmask,
  output logic              out_allzero,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and payload is held while valid.

  seq_state_e          state_q;
  logic [3:0]          ctl_q;
  logic [VLEN*EW-1:0]  va_q, vb_q, vd_q, vd_d;
  logic [VW-1:0]       vl_q, cnt_q, vl_eff, idx_b;
  logic [VLEN-1:0]     zmask_q, zmask_d, active;
  logic                allzero_q, allzero_d, run, last;
  logic [EW-1:0]       elem_a, elem_b;
  logic                bcast_q;

  assign vl_eff = (in_vl > VW'(VLEN)) ? VW'(VLEN) : in_vl;
  assign run    = (state_q == RUN);
  assign last   = (cnt_q == vl_q - VW'(1));
  assign idx_b  = bcast_q ? '0 : cnt_q;

  vec_elem_sel #(.VLEN(VLEN), .EW(EW), .IW(VW)) u_sel_a (
    .vec_i (va_q),
    .idx_i (cnt_q),
    .elem_o(elem_a)
  );

  vec_elem_sel #(.VLEN(VLEN), .EW(EW), .IW(VW)) u_sel_b (
    .vec_i (vb_q),
    .idx_i (idx_b),
    .elem_o(elem_b)
  );

  assign alu_ctl = run ? ctl_q  : '0;
  assign alu_a   = run ? elem_a : '0;
  assign alu_b   = run ? elem_b : '0;

  // Result vector and zero mask with the current ALU result merged in.
  always_comb begin
    vd_d    = vd_q;
    zmask_d = zmask_q;
    active  = '0;
    for (int i = 0; i < VLEN; i++) begin
      active[i] = (VW'(i) < vl_q);
      if (run && cnt_q == VW'(i)) begin
        vd_d[i*EW +: EW] = alu_out;
        zmask_d[i]       = alu_zero;
      end
    end
    allzero_d = &(zmask_d | ~active);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctl_q     <= '0;
      va_q      <= '0;
      vb_q      <= '0;
      vl_q      <= '0;
      cnt_q     <= '0;
      vd_q      <= '0;
      zmask_q   <= '0;
      allzero_q <= 1'b0;
      bcast_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ctl_q     <= in_ctl;
            va_q      <= in_va;
            vb_q      <= in_vb;
            vl_q      <= vl_eff;
            cnt_q     <= '0;
            vd_q      <= '0;
            zmask_q   <= '0;
            allzero_q <= (vl_eff == '0);
`ifdef VSEQ_BCAST_EN
            bcast_q   <= in_bcast;
`else
            bcast_q   <= 1'b0;
`endif
            state_q   <= (vl_eff == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          vd_q    <= vd_d;
          zmask_q <= zmask_d;
          cnt_q   <= cnt_q + VW'(1);
          if (last) begin
            allzero_q <= allzero_d;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_vd      = vd_q;
  assign out_zmask   = zmask_q;
  assign out_allzero = allzero_q;
  assign dbg_state   = state_q;

endmodule
